fifo2rsa_core: RTL
==================

# fifo2rsa_core

Engine-side counterpart of the AHB-to-FIFO slave bridge: drains 32-bit words from the forward FIFO's read port, packs them into three K-bit operands (message, exponent, modulus), and launches the RSA engine. When the engine finishes, it serializes the K-bit result into the backward FIFO's write port and raises `rsa_finish` back to the slave. It sits between the two synchronous FIFOs and the RSA datapath.

## Interface
- `K`, 128, operand/result width in bits; must be a multiple of 32, ≥ 64.
- `TIMEOUT`, 65535, WAIT-state watchdog limit in cycles. Used only with `FIFO2RSA_TIMEOUT_EN`.
- `HCLK` in 1: single clock. All logic is on the rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `rsa_start` in 1: arm level from the slave. Sampled only in IDLE.
- `rsa_finish` out 1: one-cycle pulse after the last result word is accepted.
- `frd_rdy` out 1: pop request to the forward FIFO.
- `frd_vld` in 1: forward FIFO word valid.
- `frd_dat` in 32: forward FIFO word.
- `frd_empty` in 1: forward FIFO empty. Informational; the handshake governs.
- `bwr_vld` out 1: push request to the backward FIFO.
- `bwr_dat` out 32: result word.
- `bwr_rdy` in 1: backward FIFO can accept a word.
- `bwr_full` in 1: backward FIFO full. Informational.
- `rsa_msg`, `rsa_exp`, `rsa_mod` out K: operand registers.
- `rsa_go` out 1: one-cycle engine launch pulse.
- `rsa_done` in 1: engine completion; `rsa_result` is valid in the same cycle.
- `rsa_result` in K: engine result.
- `rsa_err` out 1: sticky timeout flag. Present only with `FIFO2RSA_TIMEOUT_EN`.

## Operation
- W = K/32 words per operand. Each job loads 3W words and returns W words.
- Word transfer occurs on a cycle where `vld & rdy` are both high, on either FIFO port.
- Load order is message, then exponent, then modulus. Within each operand the least-significant word comes first.
- Result order is least-significant word first.
- States:
  - IDLE: go to LOAD when `rsa_start` is 1.
  - LOAD: `frd_rdy`=1. Each accepted word increments `wcnt`, which is ⌈log2(3W)⌉+1 bits wide. After word 3W-1 is accepted, go to GO.
  - GO: `rsa_go`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on `rsa_done`, capture `rsa_result` into the result shift register, clear `wcnt`, and go to DRAIN.
  - DRAIN: `bwr_vld`=1 and `bwr_dat` = result[31:0]. Each accepted word shifts the register right by 32. After word W-1 is accepted, pulse `rsa_finish` for one cycle and go to IDLE.
- Operand registers:
  - Hold their value after GO until the next LOAD overwrites them.
  - The word at index i goes to operand i/W, slice [32·(i mod W)+:32].
- Boundary conditions:
  - `rsa_start` outside IDLE is ignored. Re-arming while the level is still high starts a new job only after IDLE is re-entered.
  - An empty FIFO (`frd_vld`=0) stalls LOAD indefinitely with no timeout.
  - A full FIFO (`bwr_rdy`=0) holds `bwr_dat` stable and stalls DRAIN.
  - `rsa_done` outside WAIT is ignored.
  - Reset mid-job aborts to IDLE. Operands and the result register clear. No `rsa_finish` is issued.
- Reset values:
  - All outputs are 0: `frd_rdy`, `bwr_vld`, `bwr_dat`, `rsa_go`, `rsa_finish`, the operands, and `rsa_err`.
  - State is IDLE and `wcnt` is 0.

## Timing
- `rsa_start` sampled high in IDLE gives `frd_rdy`=1 on the next cycle.
- All outputs are Moore outputs, registered or decoded from the state register. None is combinational from an input.
- Throughput is one word per cycle on each port.
- Best-case latency from arm to `rsa_go` is 3W+1 cycles.
- `rsa_done` in cycle t gives `bwr_vld`=1 in cycle t+1.
- With `bwr_rdy` held high, `rsa_finish` is high in cycle t+W+1.

## Configuration
- `FIFO2RSA_TIMEOUT_EN` defined:
  - A down-counter loads `TIMEOUT` on entry to WAIT.
  - If it reaches 0 before `rsa_done`, all-ones is captured as the result, `rsa_err` sets, and the block proceeds to DRAIN.
  - `rsa_err` clears on the next IDLE→LOAD transition.
- `FIFO2RSA_TIMEOUT_EN` undefined:
  - No counter, no `rsa_err` port, and `TIMEOUT` is unused.
  - WAIT waits indefinitely.

## Structure
- Shared package `fifo2rsa_pkg` holds:
  - The state enum (IDLE, LOAD, GO, WAIT, DRAIN).
  - The function `words_per_op(K)`.
  - The word-count width constant.
- One sub-module, `rsa_operand_sreg`:
  - Indexed 32-bit write into the three operand registers.
  - Parallel-load / right-shift result register.
  - The FSM and counters stay in `fifo2rsa_core`.

## Test plan
- All scenarios use K=128 (W=4).
- Basic job:
  - Stimulus: pulse `rsa_start`; supply words 0x00000001..0x0000000C with no gaps; `rsa_done` 5 cycles after `rsa_go` with `rsa_result`=0x0D0C0B0A_09080706_05040302_01000000.
  - Response:
    - `rsa_msg`=0x00000004_00000003_00000002_00000001.
    - `rsa_mod` low word = 0x00000009.
    - Output words are 0x01000000, 0x05040302, 0x09080706, 0x0D0C0B0A.
    - `rsa_finish` pulses once.
- Load stall: deassert `frd_vld` for 10 cycles after word 6 -> `wcnt` holds at 6, no `rsa_go`, and operands are correct after resume.
- Drain backpressure: toggle `bwr_rdy` 1,0,0,1,… -> `bwr_dat` stable while stalled, exactly 4 pushes, `rsa_finish` one cycle after the 4th.
- Spurious inputs: `rsa_done` in LOAD and `rsa_start` in WAIT -> ignored, and the job completes normally.
- Reset mid-WAIT: assert `HRESETn`=0 -> all outputs 0 immediately; a fresh job afterwards completes correctly.
- Timeout (`FIFO2RSA_TIMEOUT_EN`, `TIMEOUT`=20): withhold `rsa_done` -> after 20 WAIT cycles, 4 words of 0xFFFFFFFF are pushed, `rsa_err`=1, and `rsa_err` clears on the next start.

Source files
------------

// File: rtl/fifo2rsa_pkg.sv
// Shared state encoding and sizing helpers for the FIFO-to-RSA engine bridge.
package fifo2rsa_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, GO, WAIT, DRAIN} state_e;

  localparam int WORD_W = 32;

  function automatic int words_per_op(input int k);
    return k / WORD_W;
  endfunction

  function automatic int wcnt_width(input int k);
    return $clog2(3 * words_per_op(k)) + 1;
  endfunction

  localparam int WCNT_W = wcnt_width(128);
endpackage

// File: rtl/fifo2rsa_if.sv
// FIFO-side handshake bundle: forward FIFO read port and backward FIFO write port.
interface fifo2rsa_if;
  logic        frd_rdy, frd_vld, frd_empty;
  logic [31:0] frd_dat;
  logic        bwr_vld, bwr_rdy, bwr_full;
  logic [31:0] bwr_dat;

  modport master (output frd_rdy, bwr_vld, bwr_dat,
                  input  frd_vld, frd_dat, frd_empty, bwr_rdy, bwr_full);
  modport slave  (input  frd_rdy, bwr_vld, bwr_dat,
                  output frd_vld, frd_dat, frd_empty, bwr_rdy, bwr_full);
endinterface

// File: rtl/rsa_operand_sreg.sv
// Operand storage (indexed 32-bit writes) and the result parallel-load / right-shift register.
module rsa_operand_sreg import fifo2rsa_pkg::*; #(
  parameter int K  = 128,
  parameter int CW = wcnt_width(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic [31:0]   wr_dat,
  input  logic          ld_en,
  input  logic [K-1:0]  ld_dat,
  input  logic          sh_en,
  output logic [K-1:0]  op_msg,
  output logic [K-1:0]  op_exp,
  output logic [K-1:0]  op_mod,
  output logic [31:0]   res_lo
);
  localparam int W = words_per_op(K);

  // msg, exp, mod laid end to end, so load word i lands at bit 32*i
  logic [3*K-1:0] ops_q, ops_d;
  logic [K-1:0]   res_q, res_d;

  always_comb begin
    ops_d = ops_q;
    for (int i = 0; i < 3*W; i++)
      if (wr_en && wr_idx == CW'(i)) ops_d[WORD_W*i +: WORD_W] = wr_dat;
  end

  always_comb begin
    res_d = res_q;
    if (ld_en)      res_d = ld_dat;
    else if (sh_en) res_d = {{WORD_W{1'b0}}, res_q[K-1:WORD_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
      res_q <= '0;
    end else begin
      ops_q <= ops_d;
      res_q <= res_d;
    end
  end

  assign op_msg = ops_q[K-1:0];
  assign op_exp = ops_q[2*K-1:K];
  assign op_mod = ops_q[3*K-1:2*K];
  assign res_lo = res_q[WORD_W-1:0];
endmodule

// File: rtl/fifo2rsa_core.sv
// Loads msg/exp/mod from the forward FIFO, launches the RSA engine, drains the result
// to the backward FIFO. FIFO2RSA_TIMEOUT_EN adds a WAIT watchdog and the rsa_err flag.
module fifo2rsa_core import fifo2rsa_pkg::*; #(
  parameter int K       = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         rsa_start,
  output logic         rsa_finish,
  fifo2rsa_if.master   fif,
  output logic [K-1:0] rsa_msg,
  output logic [K-1:0] rsa_exp,
  output logic [K-1:0] rsa_mod,
  output logic         rsa_go,
  input  logic         rsa_done,
  input  logic [K-1:0] rsa_result
`ifdef FIFO2RSA_TIMEOUT_EN
  , output logic       rsa_err
`endif
);
  localparam int W  = words_per_op(K);
  localparam int CW = wcnt_width(K);
  localparam logic [CW-1:0] LAST_LD = CW'(3*W-1);
  localparam logic [CW-1:0] LAST_DR = CW'(W-1);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          fin_q, fin_d;
  logic          ld_acc, dr_acc, res_ld, tmo_hit;
  logic [K-1:0]  res_in;

  // frd_rdy / bwr_vld decode LOAD / DRAIN, so only the FIFO-side valid/ready matter here
  assign ld_acc = (state_q == LOAD)  && fif.frd_vld;
  assign dr_acc = (state_q == DRAIN) && fif.bwr_rdy;
  assign res_ld = (state_q == WAIT)  && (rsa_done || tmo_hit);
  assign res_in = tmo_hit ? {K{1'b1}} : rsa_result;

`ifdef FIFO2RSA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          unused_in;

  assign tmo_hit = (state_q == WAIT) && !rsa_done && (tmo_q == TW'(1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == GO)                         tmo_d = TW'(TIMEOUT);
    else if (state_q == WAIT && tmo_q != '0)   tmo_d = tmo_q - 1'b1;
    if (state_q == IDLE && rsa_start)          err_d = 1'b0;
    else if (tmo_hit)                          err_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign rsa_err   = err_q;
  assign unused_in = ^{fif.frd_empty, fif.bwr_full};
`else
  logic unused_in;
  assign tmo_hit   = 1'b0;
  assign unused_in = ^{fif.frd_empty, fif.bwr_full, TIMEOUT[0]};
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rsa_start)                     state_d = LOAD;
      LOAD:    if (ld_acc && wcnt_q == LAST_LD)   state_d = GO;
      GO:                                         state_d = WAIT;
      WAIT:    if (res_ld)                        state_d = DRAIN;
      DRAIN:   if (dr_acc && wcnt_q == LAST_DR)   state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  always_comb begin
    fif.frd_rdy = (state_q == LOAD);
    fif.bwr_vld = (state_q == DRAIN);
    rsa_go      = (state_q == GO);
  end

  always_comb begin
    wcnt_d = wcnt_q;
    fin_d  = 1'b0;
    case (state_q)
      IDLE:  if (rsa_start) wcnt_d = '0;
      LOAD:  if (ld_acc)    wcnt_d = wcnt_q + 1'b1;
      WAIT:  if (res_ld)    wcnt_d = '0;
      DRAIN: if (dr_acc) begin
        wcnt_d = wcnt_q + 1'b1;
        fin_d  = (wcnt_q == LAST_DR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wcnt_q <= '0;
      fin_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      fin_q  <= fin_d;
    end
  end

  assign rsa_finish = fin_q;

  rsa_operand_sreg #(.K(K), .CW(CW)) u_sreg (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .wr_en  (ld_acc),
    .wr_idx (wcnt_q),
    .wr_dat (fif.frd_dat),
    .ld_en  (res_ld),
    .ld_dat (res_in),
    .sh_en  (dr_acc),
    .op_msg (rsa_msg),
    .op_exp (rsa_exp),
    .op_mod (rsa_mod),
    .res_lo (fif.bwr_dat)
  );
endmodule
